instr_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly downstream of the program counter: it takes the current fetch address from the ProgramCounter, runs a single-outstanding request/acknowledge transaction with instruction memory, and hands the fetched word and its address to the decoder through a valid/ready interface. On every accepted fetch it pulses the PC counter's increment input. On branch, jump, call or return it discards in-flight and buffered instructions.

---
 rtl/gpp_fetch_pkg.sv | 25 ++
 rtl/fetch_buffer.sv | 70 +++++++
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpp_fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// INSTR_FETCH_PREFETCH_EN selects a two-entry fetch buffer (one entry otherwise).
package gpp_fetch_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

`ifdef INSTR_FETCH_PREFETCH_EN
    localparam int FETCH_BUF_DEPTH = 2;
`else
    localparam int FETCH_BUF_DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] instr;
        logic [DEF_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small shift-style FIFO (depth 1 or 2) holding fetched {instr, pc} entries.
// Flush wins over push and pop; the head slot is always the oldest entry.
module fetch_buffer
    import gpp_fetch_pkg::*;
#(
    parameter int  DEPTH   = FETCH_BUF_DEPTH,
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t din,
    input  logic   pop,
    input  logic   flush,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    entry_t     slots     [DEPTH];
    entry_t     slots_nxt [DEPTH];
    logic [1:0] count;
    logic [1:0] count_nxt;
    logic       do_pop;
    logic       do_push;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = slots[0];

    always_comb begin
        slots_nxt = slots;
        count_nxt = count;
        if (flush) begin
            count_nxt = 2'd0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    slots_nxt[i] = slots[i+1];
                end
            end
            // write lands behind the surviving entries
            if (do_push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == int'(count) - (do_pop ? 1 : 0)) begin
                        slots_nxt[i] = din;
                    end
                end
            end
            count_nxt = count + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            count <= count_nxt;
            slots <= slots_nxt;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: single-outstanding imem request/ack, buffered hand-off to decode.
// INSTR_FETCH_PREFETCH_EN (via gpp_fetch_pkg) deepens the buffer to allow prefetch.
module instr_fetch_unit
    import gpp_fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    input  logic              redirect,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inc_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              busy
);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    fetch_state_e state;
    fetch_state_e state_nxt;
    entry_t       buf_din;
    entry_t       buf_head;
    logic         buf_full;
    logic         buf_empty;
    logic         pop;
    logic         push;
    logic         start;

    assign pop   = instr_valid && instr_ready;
    assign start = (state == IDLE) && pc_valid && !redirect && (!buf_full || pop);
    // a response that races a redirect belongs to the old path
    assign push  = (state == REQ) && imem_ack && !redirect;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ: begin
                if (imem_ack)      state_nxt = IDLE;
                else if (redirect) state_nxt = DRAIN;
            end
            DRAIN:   if (imem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            imem_addr <= '0;
            inc_pc    <= 1'b0;
        end else begin
            state  <= state_nxt;
            inc_pc <= push;
            if (start) imem_addr <= pc_in;
        end
    end

    assign imem_req = (state != IDLE);
    assign busy     = (state != IDLE);
    assign buf_din  = {imem_rdata, imem_addr};

    fetch_buffer #(
        .DEPTH   (FETCH_BUF_DEPTH),
        .entry_t (entry_t)
    ) u_fetch_buffer (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (buf_din),
        .pop   (pop),
        .flush (redirect),
        .head  (buf_head),
        .full  (buf_full),
        .empty (buf_empty)
    );

    assign instr_valid = !buf_empty;
    assign instr_out   = buf_head.instr;
    assign instr_pc    = buf_head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table of fetches plus corner sequences.
// Expectations for the two-fetch sequence follow INSTR_FETCH_PREFETCH_EN.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_in;
    logic        pc_valid;
    logic        redirect;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        inc_pc;
    logic        instr_valid;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        busy;

    int checks    = 0;
    int passes    = 0;
    int inc_count = 0;

    typedef struct {
        logic [15:0] addr;
        int          waits;
        logic [15:0] rdata;
        logic [15:0] exp_instr;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs [5];

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .redirect    (redirect),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inc_pc      (inc_pc),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && inc_pc) inc_count++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input string tag, input logic [15:0] addr, input int waits,
                            input logic [15:0] rdata, input logic [15:0] exp_instr,
                            input logic [15:0] exp_pc);
        int good;
        int inc0;
        good = 0;
        inc0 = inc_count;
        pc_in = addr;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin
                imem_ack = 1'b1;
                imem_rdata = rdata;
            end
            @(negedge clk);
            if (imem_req && imem_addr == addr) good++;
            if (i == waits) check({tag, "_valid_early"}, 32'(instr_valid), 32'd0);
            step();
        end
        imem_ack = 1'b0;
        imem_rdata = 16'h0;
        check({tag, "_req_held"}, good, waits + 1);
        @(negedge clk);
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_instr_out"}, 32'(instr_out), 32'(exp_instr));
        check({tag, "_instr_pc"}, 32'(instr_pc), 32'(exp_pc));
        check({tag, "_req_drop"}, 32'(imem_req), 32'd0);
        step();
        @(negedge clk);
        check({tag, "_inc_pulses"}, inc_count - inc0, 1);
        check({tag, "_inc_low"}, 32'(inc_pc), 32'd0);
    endtask

    task automatic pop_one(input string tag);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        @(negedge clk);
        check({tag, "_popped"}, 32'(instr_valid), 32'd0);
    endtask

    initial begin
        int inc0;
        int held;
        int waited;

        vecs[0] = '{16'h0010, 0, 16'hA55A, 16'hA55A, 16'h0010};
        vecs[1] = '{16'h0020, 3, 16'h1234, 16'h1234, 16'h0020};
        vecs[2] = '{16'hFFFF, 1, 16'hBEEF, 16'hBEEF, 16'hFFFF};
        vecs[3] = '{16'h0000, 2, 16'h0001, 16'h0001, 16'h0000};
        vecs[4] = '{16'h8000, 0, 16'hFFFF, 16'hFFFF, 16'h8000};

        reset = 1'b0;
        pc_in = 16'h0;
        pc_valid = 1'b0;
        redirect = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 16'h0;
        instr_ready = 1'b0;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_inc_pc", 32'(inc_pc), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_out", 32'(instr_out), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        step();
        step();
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        for (int v = 0; v < 5; v++) begin
            do_fetch($sformatf("vec%0d", v), vecs[v].addr, vecs[v].waits, vecs[v].rdata,
                     vecs[v].exp_instr, vecs[v].exp_pc);
            pop_one($sformatf("vec%0d", v));
        end

        // two fetches while the decoder stalls
        do_fetch("ordA", 16'h0040, 0, 16'h1111, 16'h1111, 16'h0040);
        inc0 = inc_count;
        pc_in = 16'h0042;
        pc_valid = 1'b1;
`ifdef INSTR_FETCH_PREFETCH_EN
        step();
        pc_valid = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 16'h2222;
        @(negedge clk);
        check("pf_req", 32'(imem_req), 32'd1);
        check("pf_addr", 32'(imem_addr), 32'h0042);
        step();
        imem_ack = 1'b0;
        @(negedge clk);
        check("pf_head_first", 32'(instr_out), 32'h1111);
        instr_ready = 1'b1;
        step();
        @(negedge clk);
        check("pf_head_second", 32'(instr_out), 32'h2222);
        check("pf_head_second_pc", 32'(instr_pc), 32'h0042);
        check("pf_valid_second", 32'(instr_valid), 32'd1);
        step();
        instr_ready = 1'b0;
        @(negedge clk);
        check("pf_drained", 32'(instr_valid), 32'd0);
`else
        waited = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            if (!imem_req) waited++;
        end
        check("nopf_req_blocked", waited, 3);
        check("nopf_head_first", 32'(instr_out), 32'h1111);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        pc_valid = 1'b0;
        @(negedge clk);
        check("nopf_req", 32'(imem_req), 32'd1);
        check("nopf_addr", 32'(imem_addr), 32'h0042);
        check("nopf_valid_gap", 32'(instr_valid), 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 16'h2222;
        step();
        imem_ack = 1'b0;
        @(negedge clk);
        check("nopf_head_second", 32'(instr_out), 32'h2222);
        check("nopf_valid_second", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
`endif
        @(negedge clk);
        check("ord_inc_pulses", inc_count - inc0, 1);

        // redirect in the second wait cycle: request held until ack, data dropped
        inc0 = inc_count;
        held = 0;
        pc_in = 16'h0030;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        @(negedge clk);
        if (imem_req && imem_addr == 16'h0030) held++;
        step();
        redirect = 1'b1;
        @(negedge clk);
        if (imem_req && imem_addr == 16'h0030) held++;
        step();
        redirect = 1'b0;
        @(negedge clk);
        if (imem_req && imem_addr == 16'h0030) held++;
        check("drain_busy", 32'(busy), 32'd1);
        step();
        imem_ack = 1'b1;
        imem_rdata = 16'hDEAD;
        @(negedge clk);
        if (imem_req && imem_addr == 16'h0030) held++;
        step();
        imem_ack = 1'b0;
        check("drain_req_held", held, 4);
        @(negedge clk);
        check("drain_req_drop", 32'(imem_req), 32'd0);
        check("drain_valid", 32'(instr_valid), 32'd0);
        check("drain_busy_end", 32'(busy), 32'd0);
        step();
        @(negedge clk);
        check("drain_no_inc", inc_count - inc0, 0);
        check("drain_valid_late", 32'(instr_valid), 32'd0);
        do_fetch("post_redir", 16'h0100, 1, 16'h7777, 16'h7777, 16'h0100);
        pop_one("post_redir");

        // redirect together with ack in REQ: response discarded
        inc0 = inc_count;
        pc_in = 16'h0300;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        redirect = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 16'hBAD0;
        step();
        redirect = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        check("racek_req", 32'(imem_req), 32'd0);
        check("racek_valid", 32'(instr_valid), 32'd0);
        step();
        @(negedge clk);
        check("racek_no_inc", inc_count - inc0, 0);

        // redirect with a full buffer and a same-cycle pop
        do_fetch("flush", 16'h0200, 0, 16'h5555, 16'h5555, 16'h0200);
        instr_ready = 1'b1;
        redirect = 1'b1;
        step();
        instr_ready = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        check("flush_valid", 32'(instr_valid), 32'd0);
        step();
        @(negedge clk);
        check("flush_valid_late", 32'(instr_valid), 32'd0);

        // asynchronous reset in the middle of REQ, then a late ack
        do_fetch("rst", 16'h0400, 0, 16'h9999, 16'h9999, 16'h0400);
        instr_ready = 1'b1;
        pc_in = 16'h0402;
        pc_valid = 1'b1;
        step();
        instr_ready = 1'b0;
        pc_valid = 1'b0;
        @(negedge clk);
        check("midrst_pre_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_imem_req", 32'(imem_req), 32'd0);
        check("midrst_imem_addr", 32'(imem_addr), 32'd0);
        check("midrst_inc_pc", 32'(inc_pc), 32'd0);
        check("midrst_instr_valid", 32'(instr_valid), 32'd0);
        check("midrst_instr_out", 32'(instr_out), 32'd0);
        check("midrst_instr_pc", 32'(instr_pc), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        step();
        imem_ack = 1'b1;
        imem_rdata = 16'h6666;
        reset = 1'b1;
        inc0 = inc_count;
        step();
        imem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_valid", 32'(instr_valid), 32'd0);
        check("late_ack_req", 32'(imem_req), 32'd0);
        step();
        @(negedge clk);
        check("late_ack_no_inc", inc_count - inc0, 0);
        check("late_ack_valid2", 32'(instr_valid), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
